// File: rtl/parity_pkg.sv
// Shared definitions for the odd-parity serial link (transmitter and checker).
package parity_pkg;

    // Transmitter frame sequencing states.
    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        DATA   = 2'd1,
        PARITY = 2'd2
    } tx_state_t;

    // Level held on the serial line between frames.
    localparam logic LINE_IDLE = 1'b1;

    // Odd parity bit for a word of up to 32 bits. Narrower words are
    // zero-extended by the caller; the extra zeros do not change the result.
    function automatic logic odd_parity(input logic [31:0] data);
        return ~^data;
    endfunction

endpackage : parity_pkg

// File: rtl/odd_parity_tx.sv
// Odd-parity serial transmitter: accepts a word on load/ready, sends it
// LSB-first followed by one parity bit making the frame's ones count odd.
module odd_parity_tx
    import parity_pkg::*;
#(
    parameter int DATA_W = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [DATA_W-1:0] data_in,
    input  logic              load,
    output logic              ready,
    output logic              tx_out,
    output logic              tx_valid,
    output logic              tx_first,
    output logic              tx_last
);

    // Bit counter is just wide enough to index DATA_W bits.
    localparam int CNT_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;
    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(DATA_W - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    tx_state_t         state_r;
    logic [DATA_W-1:0] shift_r;
    logic [CNT_W-1:0]  cnt_r;
    logic              parity_r;

    // Idle is the only state that can take a new word.
    assign ready = (state_r == IDLE);

    // Frame sequencer. Outputs are registered one state ahead: the edge that
    // enters a state also loads the line value shown during that state, so
    // bit 0 appears in the cycle right after the accepting edge. The shift
    // register holds the word with the bit currently on the line at index 0,
    // so the next bit to show is always shift_r[1].
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r  <= IDLE;
            shift_r  <= '0;
            cnt_r    <= '0;
            parity_r <= 1'b0;
            tx_out   <= LINE_IDLE;
            tx_valid <= 1'b0;
            tx_first <= 1'b0;
            tx_last  <= 1'b0;
        end else begin
            case (state_r)
                IDLE: begin
                    if (load) begin
                        state_r  <= DATA;
                        shift_r  <= data_in;
                        cnt_r    <= '0;
                        parity_r <= odd_parity(32'(data_in));
                        tx_out   <= data_in[0];
                        tx_valid <= 1'b1;
                        tx_first <= 1'b1;
                        tx_last  <= 1'b0;
                    end else begin
                        state_r  <= IDLE;
                        shift_r  <= shift_r;
                        cnt_r    <= cnt_r;
                        parity_r <= parity_r;
                        tx_out   <= LINE_IDLE;
                        tx_valid <= 1'b0;
                        tx_first <= 1'b0;
                        tx_last  <= 1'b0;
                    end
                end

                DATA: begin
                    shift_r  <= shift_r >> 1;
                    parity_r <= parity_r;
                    tx_valid <= 1'b1;
                    tx_first <= 1'b0;
                    if (cnt_r == LAST_BIT) begin
                        // Last data bit is on the line; parity follows. The
                        // counter holds here so it never wraps inside a frame.
                        state_r <= PARITY;
                        cnt_r   <= cnt_r;
                        tx_out  <= parity_r;
                        tx_last <= 1'b1;
                    end else begin
                        state_r <= DATA;
                        cnt_r   <= cnt_r + CNT_ONE;
                        tx_out  <= shift_r[1];
                        tx_last <= 1'b0;
                    end
                end

                PARITY: begin
                    // Return the line to idle; a load seen now is ignored.
                    state_r  <= IDLE;
                    shift_r  <= shift_r;
                    cnt_r    <= cnt_r;
                    parity_r <= parity_r;
                    tx_out   <= LINE_IDLE;
                    tx_valid <= 1'b0;
                    tx_first <= 1'b0;
                    tx_last  <= 1'b0;
                end

                default: begin
                    // Unreachable encoding: recover to a clean idle line.
                    state_r  <= IDLE;
                    shift_r  <= '0;
                    cnt_r    <= '0;
                    parity_r <= 1'b0;
                    tx_out   <= LINE_IDLE;
                    tx_valid <= 1'b0;
                    tx_first <= 1'b0;
                    tx_last  <= 1'b0;
                end
            endcase
        end
    end

endmodule : odd_parity_tx

// File: tb/tb_odd_parity_tx.sv
// Self-checking bench for odd_parity_tx: directed scenarios plus a random
// regression, all compared cycle by cycle with a frame-level reference model.
module tb_odd_parity_tx;
    import parity_pkg::*;

    localparam int DATA_W = 8;

    logic              clk = 1'b0;
    logic              rst;
    logic              load;
    logic [DATA_W-1:0] data_in;
    logic              ready;
    logic              tx_out;
    logic              tx_valid;
    logic              tx_first;
    logic              tx_last;

    odd_parity_tx #(.DATA_W(DATA_W)) dut (
        .clk      (clk),
        .rst      (rst),
        .data_in  (data_in),
        .load     (load),
        .ready    (ready),
        .tx_out   (tx_out),
        .tx_valid (tx_valid),
        .tx_first (tx_first),
        .tx_last  (tx_last)
    );

    always #5 clk = ~clk;

    // One expected line cycle.
    typedef struct packed {
        logic out;
        logic valid;
        logic first;
        logic last;
    } rec_t;

    localparam rec_t IDLE_REC = '{out: 1'b1, valid: 1'b0, first: 1'b0, last: 1'b0};

    rec_t q[$];
    rec_t exp_r = IDLE_REC;
    int   errors = 0;
    int   checks = 0;
    int   accepted = 0;
    int   frames_done = 0;

    // Scoreboard of the observed line.
    logic [DATA_W-1:0] sb_word = '0;
    int                sb_idx = 0;
    int                sb_ones = 0;
    logic [DATA_W-1:0] last_word = '0;

    task automatic chk(input string tag, input logic obs, input logic expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s: observed=%b expected=%b at %0t", tag, obs, expv, $time);
        end
    endtask

    // Reference model, one rising edge: a frame is the word's bits LSB-first
    // then a parity bit making the ones count odd; it starts the cycle after
    // a load seen while the line was idle.
    task automatic model_edge(input logic l, input logic [DATA_W-1:0] d);
        rec_t r;
        if (rst) begin
            q.delete();
            exp_r = IDLE_REC;
        end else if (!exp_r.valid && l) begin
            for (int i = 0; i < DATA_W; i++) begin
                r.out   = d[i];
                r.valid = 1'b1;
                r.first = (i == 0);
                r.last  = 1'b0;
                q.push_back(r);
            end
            r.out   = ($countones(d) % 2 == 0);
            r.valid = 1'b1;
            r.first = 1'b0;
            r.last  = 1'b1;
            q.push_back(r);
            exp_r = q.pop_front();
            accepted++;
        end else if (q.size() > 0) begin
            exp_r = q.pop_front();
        end else begin
            exp_r = IDLE_REC;
        end
    endtask

    task automatic check_outputs();
        chk("tx_out",   tx_out,   exp_r.out);
        chk("tx_valid", tx_valid, exp_r.valid);
        chk("tx_first", tx_first, exp_r.first);
        chk("tx_last",  tx_last,  exp_r.last);
        chk("ready",    ready,    !exp_r.valid);
        if (tx_valid === 1'b1) begin
            if (tx_first === 1'b1) begin
                sb_word = '0;
                sb_idx  = 0;
                sb_ones = 0;
            end
            if (tx_last !== 1'b1) begin
                if (sb_idx < DATA_W) sb_word[sb_idx] = tx_out;
                sb_idx++;
                sb_ones += int'(tx_out);
            end else begin
                sb_ones += int'(tx_out);
                chk("frame_odd", (sb_ones % 2 == 1), 1'b1);
                chk("frame_len", (sb_idx == DATA_W), 1'b1);
                last_word = sb_word;
                frames_done++;
            end
        end
    endtask

    task automatic step(input logic l, input logic [DATA_W-1:0] d);
        load    = l;
        data_in = d;
        @(posedge clk);
        model_edge(l, d);
        #1;
        check_outputs();
    endtask

    initial begin
        logic [DATA_W-1:0] a5;
        logic [DATA_W-1:0] sweep_w [4];
        logic              sweep_p [4];
        int                f0;
        int                start;
        int                cyc;

        a5 = 8'hA5;
        sweep_w = '{8'h00, 8'hFF, 8'h01, 8'h07};
        sweep_p = '{1'b1, 1'b1, 1'b0, 1'b0};

        // Reset state, including a load held during reset.
        rst = 1'b1;
        load = 1'b0;
        data_in = '0;
        #2;
        check_outputs();
        step(1'b1, 8'h3C);
        step(1'b0, 8'h00);
        rst = 1'b0;
        step(1'b0, 8'h00);

        // 0xA5 frame with explicit expectations.
        step(1'b1, a5);
        chk("a5_ready_low", ready, 1'b0);
        for (int i = 0; i < DATA_W; i++) begin
            if (i > 0) step(1'b0, 8'h00);
            chk("a5_bit", tx_out, a5[i]);
            chk("a5_first", tx_first, (i == 0));
        end
        step(1'b0, 8'h00);
        chk("a5_parity", tx_out, 1'b1);
        chk("a5_last", tx_last, 1'b1);
        step(1'b0, 8'h00);
        chk("a5_ready_back", ready, 1'b1);

        // Parity sweep.
        for (int w = 0; w < 4; w++) begin
            step(1'b1, sweep_w[w]);
            for (int i = 1; i < DATA_W; i++) step(1'b0, 8'h00);
            step(1'b0, 8'h00);
            chk("sweep_last", tx_last, 1'b1);
            chk("sweep_parity", tx_out, sweep_p[w]);
            step(1'b0, 8'h00);
        end

        // Load pulsed during data bit 3 is ignored.
        f0 = frames_done;
        step(1'b1, 8'h96);
        for (int i = 1; i <= 3; i++) step(1'b0, 8'h00);
        step(1'b1, 8'h3C);
        for (int i = 0; i < 14; i++) step(1'b0, 8'h00);
        chk("ignore_word", (last_word == 8'h96), 1'b1);
        chk("ignore_frames", (frames_done - f0 == 1), 1'b1);

        // Load held: back-to-back frames with exactly one idle cycle.
        step(1'b1, 8'h55);
        for (int j = 0; j < 10; j++) begin
            step(1'b1, 8'hAA);
            if (j == 8) begin
                chk("hold_gap_valid", tx_valid, 1'b0);
                chk("hold_gap_line", tx_out, 1'b1);
            end
            if (j == 9) chk("hold_second_first", tx_first, 1'b1);
        end
        for (int i = 0; i < 10; i++) step(1'b0, 8'h00);
        chk("hold_second_word", (last_word == 8'hAA), 1'b1);

        // Asynchronous reset at bit 4 of 0xF0.
        f0 = frames_done;
        step(1'b1, 8'hF0);
        for (int i = 0; i < 4; i++) step(1'b0, 8'h00);
        chk("rst_pre_bit4", tx_out, 1'b1);
        #2;
        rst = 1'b1;
        #1;
        q.delete();
        exp_r = IDLE_REC;
        chk("rst_async_out", tx_out, 1'b1);
        chk("rst_async_valid", tx_valid, 1'b0);
        chk("rst_async_ready", ready, 1'b1);
        chk("rst_async_last", tx_last, 1'b0);
        step(1'b1, 8'h0F);
        rst = 1'b0;
        for (int i = 0; i < 12; i++) step(1'b0, 8'h00);
        chk("rst_no_parity", (frames_done == f0), 1'b1);
        step(1'b1, 8'h0F);
        for (int i = 1; i < DATA_W; i++) step(1'b0, 8'h00);
        step(1'b0, 8'h00);
        chk("post_rst_parity", tx_out, 1'b1);
        step(1'b0, 8'h00);
        chk("post_rst_word", (last_word == 8'h0F), 1'b1);

        // Random regression: 1000 words, random gaps and stray loads.
        start = accepted;
        cyc = 0;
        while ((accepted - start) < 1000 && cyc < 40000) begin
            step(1'($urandom_range(0, 1)), 8'($urandom));
            cyc++;
        end
        for (int i = 0; i < DATA_W + 2; i++) step(1'b0, 8'h00);
        chk("rand_words_sent", ((accepted - start) >= 1000), 1'b1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule : tb_odd_parity_tx
